// File: rtl/z80_io_ctrl.sv
// Z80 sound-CPU I/O glue: strobe synchroniser, port decode, 68k command/reply
// mailbox with NMI, and M1 ROM bank windows.
module z80_io_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SDA,
  input  logic [7:0]  SDD_WR,
  output logic [7:0]  SDD_RD,
  input  logic        nIORQ,
  input  logic        nMREQ,
  input  logic        nRD,
  input  logic        nWR,
  output logic        nNMI,
  input  logic        CMD_WE,
  input  logic [7:0]  CMD_DATA,
  output logic [7:0]  SND_REPLY,
  output logic [21:0] ROM_ADDR,
  output logic        RAM_SEL,
  output logic        YM_CS,
  output logic [1:0]  YM_A
);

  logic [2:0]       r_s1, r_s2;   // {nIORQ, nRD, nWR}
  logic             r_rd_d, r_wr_d;
  logic             r_fill, r_rd_arm, r_wr_arm;
  logic [7:0]       r_cmd, r_reply;
  logic             r_pend, r_en, r_nnmi;
  logic [3:0][7:0]  r_bank;

  logic w_rd_n, w_wr_n, w_rd_ev, w_wr_ev;
  logic w_pend_nx, w_en_nx;
  logic [1:0] w_port;

  assign w_port  = SDA[3:2];
  assign w_rd_n  = r_s2[2] | r_s2[1];
  assign w_wr_n  = r_s2[2] | r_s2[0];
  // Edges only count once the strobe has been seen idle since reset, so a
  // strobe held low across reset cannot fire.
  assign w_rd_ev = r_rd_arm & r_rd_d & ~w_rd_n;
  assign w_wr_ev = r_wr_arm & r_wr_d & ~w_wr_n;

  always_comb begin
    w_pend_nx = r_pend;
    w_en_nx   = r_en;
    if (w_rd_ev && w_port == 2'b00) w_pend_nx = 1'b0;
    if (CMD_WE)                     w_pend_nx = 1'b1;
    if (w_wr_ev && w_port == 2'b10) w_en_nx   = ~SDA[4];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1     <= 3'b111;
      r_s2     <= 3'b111;
      r_rd_d   <= 1'b1;
      r_wr_d   <= 1'b1;
      r_fill   <= 1'b0;
      r_rd_arm <= 1'b0;
      r_wr_arm <= 1'b0;
      r_cmd    <= 8'h00;
      r_reply  <= 8'h00;
      r_pend   <= 1'b0;
      r_en     <= 1'b0;
      r_nnmi   <= 1'b1;
      r_bank   <= {8'h02, 8'h06, 8'h0E, 8'h1E};
    end else begin
      r_s1     <= {nIORQ, nRD, nWR};
      r_s2     <= r_s1;
      r_rd_d   <= w_rd_n;
      r_wr_d   <= w_wr_n;
      r_fill   <= 1'b1;
      r_rd_arm <= r_rd_arm | (r_fill & (r_s1[2] | r_s1[1]));
      r_wr_arm <= r_wr_arm | (r_fill & (r_s1[2] | r_s1[0]));
      r_pend   <= w_pend_nx;
      r_en     <= w_en_nx;
      r_nnmi   <= ~(w_pend_nx & w_en_nx);
      if (CMD_WE)                     r_cmd   <= CMD_DATA;
      if (w_wr_ev && w_port == 2'b11) r_reply <= SDD_WR;
      if (w_rd_ev && w_port == 2'b10) r_bank[SDA[1:0]] <= SDA[15:8];
    end
  end

  always_comb begin
    case (w_port)
      2'b00:   SDD_RD = r_cmd;
      2'b10:   SDD_RD = 8'h00;
      default: SDD_RD = 8'hFF;
    endcase
  end

  always_comb begin
    casez (SDA[15:11])
      5'b0????: ROM_ADDR = {7'b0, SDA[14:0]};
      5'b10???: ROM_ADDR = {r_bank[3], SDA[13:0]};
      5'b110??: ROM_ADDR = {1'b0, r_bank[2], SDA[12:0]};
      5'b1110?: ROM_ADDR = {2'b0, r_bank[1], SDA[11:0]};
      5'b11110: ROM_ADDR = {3'b0, r_bank[0], SDA[10:0]};
      default:  ROM_ADDR = {6'b0, SDA};
    endcase
  end

  assign RAM_SEL   = ~nMREQ & (SDA[15:11] == 5'b11111);
  assign YM_CS     = ~nIORQ & (w_port == 2'b01);
  assign YM_A      = SDA[1:0];
  assign nNMI      = r_nnmi;
  assign SND_REPLY = r_reply;

endmodule
